uart_rx_param: RTL and testbench

Synthesisable, parametrised UART receiver. It replaces the bit-banged serial path that the bench currently drives into the processor's RXD / RX-DMA input. It adds configurable data width, parity, stop bits, mid-bit sampling, start-bit glitch rejection, error flags and a valid/ready output handshake. It sits between the RXD pad (asynchronous) and the RX DMA, which consumes bytes through Data_Valid/Data_Ready.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx_param.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the UART blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BREAK
  } rx_state_t;

  // Clock cycles per bit period, truncated towards zero.
  function automatic int bit_cycles(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high lines do not see a false edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: mid-bit sampling, glitch rejection, parity/frame
// error flags, break handling and a valid/ready output with overrun pulse.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int FREQ_CLK  = 100000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  input  logic                 Data_Ready,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int BIT_CYCLES = bit_cycles(FREQ_CLK, BAUD);
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);

  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(BIT_CYCLES - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam parity_t       PAR_MODE  = parity_t'(PARITY[1:0]);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data_bits
    $error("uart_rx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_err_parity
    $error("uart_rx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (BIT_CYCLES < 4) begin : g_err_bit_cycles
    $error("uart_rx_param: FREQ_CLK/BAUD must be at least 4");
  end

  logic rxd_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (Clk),
    .srst (Rst),
    .d    (RXD),
    .q    (rxd_s)
  );

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 rxd_prev_q, rxd_prev_d;
  logic                 complete;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    rxd_prev_d = rxd_s;
    complete   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxd_prev_q && !rxd_s) begin
          state_d   = START;
          bit_idx_d = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_DATA) begin
            bit_idx_d = '0;
            state_d   = (PAR_MODE == PAR_NONE) ? STOP : PAR;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          perr_d  = (^shift_q) ^ rxd_s ^ (PAR_MODE == PAR_ODD);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rxd_s;
          if (bit_idx_q == LAST_STOP) begin
            complete  = 1'b1;
            bit_idx_d = '0;
            // A low final stop bit may be a break; hold off until the line idles.
            state_d   = rxd_s ? IDLE : BREAK;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    ovr_d  = 1'b0;
    accept = dv_q && Data_Ready;

    if (accept) begin
      dv_d = 1'b0;
    end
    if (complete) begin
      if (!dv_q || accept) begin
        dv_d   = 1'b1;
        dout_d = shift_q;
        pe_d   = perr_q;
        fe_d   = ferr_d;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rxd_prev_q <= 1'b1;
      dout_q     <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      rxd_prev_q <= rxd_prev_d;
      dout_q     <= dout_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign Data_Out   = dout_q;
  assign Data_Valid = dv_q;
  assign Parity_Err = pe_q;
  assign Frame_Err  = fe_q;
  assign Overrun    = ovr_q;
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 receiver at default rates and a fast
// 8E1 receiver, with a scoreboard queue per receiver checked on each accept.
module tb_uart_rx_param;

  localparam int BIT_A  = 100000000 / 115200;
  localparam int HALF_A = BIT_A / 2;
  localparam int LAT_A  = 2 + HALF_A + (8 + 0 + 1) * BIT_A + 1;
  localparam int BIT_B  = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rxd_a, rxd_b;
  logic       ready_a, ready_b;
  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b;
  logic       pe_a, pe_b;
  logic       fe_a, fe_b;
  logic       ovr_a, ovr_b;
  logic       busy_a, busy_b;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_rise = -1;
  int   ovr_count = 0;
  logic dv_a_prev = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];

  uart_rx_param u_dut_a (
    .Clk        (clk),
    .Rst        (rst),
    .RXD        (rxd_a),
    .Data_Out   (dout_a),
    .Data_Valid (dv_a),
    .Data_Ready (ready_a),
    .Parity_Err (pe_a),
    .Frame_Err  (fe_a),
    .Overrun    (ovr_a),
    .Busy       (busy_a)
  );

  uart_rx_param #(
    .FREQ_CLK  (1600),
    .BAUD      (100),
    .DATA_BITS (8),
    .PARITY    (1),
    .STOP_BITS (1)
  ) u_dut_b (
    .Clk        (clk),
    .Rst        (rst),
    .RXD        (rxd_b),
    .Data_Out   (dout_b),
    .Data_Valid (dv_b),
    .Data_Ready (ready_b),
    .Parity_Err (pe_b),
    .Frame_Err  (fe_b),
    .Overrun    (ovr_b),
    .Busy       (busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.pe   = pe;
    e.fe   = fe;
    return e;
  endfunction

  // Scoreboard: every word accepted by the consumer must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && dv_a && ready_a) begin
      chk("a_word_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("a_data", 32'(dout_a), 32'(e.data));
        chk("a_parity_err", 32'(pe_a), 32'(e.pe));
        chk("a_frame_err", 32'(fe_a), 32'(e.fe));
        $display("rx_a word=0x%02h pe=%0d fe=%0d", dout_a, pe_a, fe_a);
      end
    end
    if (!rst && dv_b && ready_b) begin
      chk("b_word_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("b_data", 32'(dout_b), 32'(e.data));
        chk("b_parity_err", 32'(pe_b), 32'(e.pe));
        chk("b_frame_err", 32'(fe_b), 32'(e.fe));
        $display("rx_b word=0x%02h pe=%0d fe=%0d", dout_b, pe_b, fe_b);
      end
    end
    if (ovr_a) ovr_count++;
    if (dv_a && !dv_a_prev) last_rise = cyc;
    dv_a_prev = dv_a;
  end

  task automatic drive_line(input int sel, input logic val, input int ncyc);
    if (sel == 0) rxd_a = val;
    else rxd_b = val;
    repeat (ncyc) @(negedge clk);
  endtask

  // Start bit, then nbits of 'bits' LSB first (data, optional parity, stop).
  task automatic uart_send(input int sel, input logic [15:0] bits, input int nbits, input int bitcyc);
    drive_line(sel, 1'b0, bitcyc);
    for (int i = 0; i < nbits; i++) drive_line(sel, bits[i], bitcyc);
  endtask

  initial begin
    int          c0;
    logic [15:0] frame;
    logic [7:0]  d;

    rst = 1'b1;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_dv", 32'(dv_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_dout", 32'(dout_a), 32'd0);
    chk("rst_flags", 32'({pe_a, fe_a, ovr_a}), 32'd0);
    chk("rst_b_outputs", 32'({dv_b, busy_b, pe_b, fe_b, ovr_b}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: 8N1 frame 0xAB, latency from first low cycle at the pin.
    q_a.push_back(mk(8'hAB, 1'b0, 1'b0));
    c0 = cyc;
    frame = {7'd0, 1'b1, 8'hAB};
    uart_send(0, frame, 9, BIT_A);
    chk("t1_latency", 32'(last_rise - c0), 32'(LAT_A));
    chk("t1_dv_single_cycle", 32'(dv_a), 32'd0);

    // 2: even parity, correct then wrong parity bit.
    q_b.push_back(mk(8'hAB, 1'b0, 1'b0));
    frame = {6'd0, 1'b1, 1'b1, 8'hAB};
    uart_send(1, frame, 10, BIT_B);
    q_b.push_back(mk(8'hAB, 1'b1, 1'b0));
    frame = {6'd0, 1'b1, 1'b0, 8'hAB};
    uart_send(1, frame, 10, BIT_B);
    drive_line(1, 1'b1, 2 * BIT_B);

    // 3: stop bit low followed by a 20-bit break, then a clean frame.
    q_a.push_back(mk(8'h55, 1'b0, 1'b1));
    d = 8'h55;
    drive_line(0, 1'b0, BIT_A);
    for (int i = 0; i < 8; i++) drive_line(0, d[i], BIT_A);
    drive_line(0, 1'b0, 20 * BIT_A);
    chk("t3_busy_in_break", 32'(busy_a), 32'd1);
    drive_line(0, 1'b1, 8);
    chk("t3_idle_after_break", 32'(busy_a), 32'd0);
    q_a.push_back(mk(8'h3C, 1'b0, 1'b0));
    frame = {7'd0, 1'b1, 8'h3C};
    uart_send(0, frame, 9, BIT_A);

    // 4: consumer stalled, second frame overruns.
    ready_a = 1'b0;
    ovr_count = 0;
    q_a.push_back(mk(8'hAB, 1'b0, 1'b0));
    frame = {7'd0, 1'b1, 8'hAB};
    uart_send(0, frame, 9, BIT_A);
    frame = {7'd0, 1'b1, 8'hCD};
    uart_send(0, frame, 9, BIT_A);
    chk("t4_dv_held", 32'(dv_a), 32'd1);
    chk("t4_dout_held", 32'(dout_a), 32'hAB);
    chk("t4_overrun_pulses", 32'(ovr_count), 32'd1);
    @(posedge clk);
    #1 ready_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_dv_dropped", 32'(dv_a), 32'd0);
    chk("t4_overrun_total", 32'(ovr_count), 32'd1);

    // 5: 100-cycle low glitch is rejected at mid start bit.
    c0 = cyc;
    rxd_a = 1'b0;
    for (int k = 1; k <= HALF_A + 3; k++) begin
      @(negedge clk);
      if (k == 100) rxd_a = 1'b1;
      if (k == 3) chk("t5_busy_start", 32'(busy_a), 32'd1);
      if (k == HALF_A + 2) chk("t5_busy_before_sample", 32'(busy_a), 32'd1);
      if (k == HALF_A + 3) chk("t5_busy_released", 32'(busy_a), 32'd0);
    end
    chk("t5_cycles_elapsed", 32'(cyc - c0), 32'(HALF_A + 3));
    drive_line(0, 1'b1, BIT_A);

    // 6: reset during data bit 3 aborts the frame; next frame is clean.
    d = 8'h5A;
    drive_line(0, 1'b0, BIT_A);
    for (int i = 0; i < 3; i++) drive_line(0, d[i], BIT_A);
    drive_line(0, d[3], BIT_A / 2);
    chk("t6_busy_mid_frame", 32'(busy_a), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    rxd_a = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy_a), 32'd0);
    chk("t6_rst_dv", 32'(dv_a), 32'd0);
    chk("t6_rst_dout", 32'(dout_a), 32'd0);
    chk("t6_rst_flags", 32'({pe_a, fe_a, ovr_a}), 32'd0);
    drive_line(0, 1'b1, 2 * BIT_A);
    q_a.push_back(mk(8'hA5, 1'b0, 1'b0));
    frame = {7'd0, 1'b1, 8'hA5};
    uart_send(0, frame, 9, BIT_A);
    drive_line(0, 1'b1, 16);

    chk("end_queue_a_empty", 32'(q_a.size()), 32'd0);
    chk("end_queue_b_empty", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
